// File: rtl/header_dispatcher_if.sv
// NoC port bundle for header_dispatcher: send-side flit/credit and eject-side flit/credit.
// master = dispatcher side, slave = router side.
interface header_dispatcher_if;
    logic [72:0] putFlit;
    logic        EN_putFlit;
    logic [2:0]  getCredit;
    logic [72:0] flit;
    logic        send_credit;
    logic [2:0]  credit_in;

    modport master (
        output putFlit, EN_putFlit, send_credit, credit_in,
        input  getCredit, flit
    );

    modport slave (
        input  putFlit, EN_putFlit, send_credit, credit_in,
        output getCredit, flit
    );
endinterface

// File: rtl/header_dispatcher.sv
// Node-0 controller: broadcasts a 640-bit header as 10-flit packets to PEs 1..NUM_PE
// under VC0 credit flow control, then captures the first well-formed result packet.
module header_dispatcher #(
    parameter int unsigned NUM_PE       = 5,
    parameter int unsigned CREDIT_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [639:0]         header,
    header_dispatcher_if.master  noc,
    output logic                 busy,
    output logic                 found,
    output logic [4:0]           found_pe,
    output logic [31:0]          found_nonce,
    output logic [63:0]          found_clk
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [639:0]  r_header;
    logic [4:0]    r_pe_idx;
    logic [3:0]    r_word;
    logic [3:0]    r_credit_cnt;
    logic [72:0]   r_putFlit;
    logic          r_en_putFlit;
    logic          r_send_credit;
    logic [2:0]    r_credit_in;
    logic [1:0]    r_pword;
    logic          r_drop;
    logic [31:0]   r_nonce;
    logic          r_found;
    logic [4:0]    r_found_pe;
    logic [31:0]   r_found_nonce;
    logic [63:0]   r_found_clk;

    logic          w_start_ok;
    logic          w_send;
    logic          w_last;
    logic          w_cr_in;
    logic          w_fv;
    logic          w_ftail;
    logic [63:0]   w_fdata;
    logic          w_good_tail;
    logic          w_capture;
    logic          w_unused;

    assign w_fv        = noc.flit[72];
    assign w_ftail     = noc.flit[71];
    assign w_fdata     = noc.flit[63:0];
    assign w_unused    = ^noc.flit[70:64];
    assign w_cr_in     = (noc.getCredit == 3'b100);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_send      = (r_state == S_SEND) && (r_credit_cnt != '0);
    assign w_last      = (r_pe_idx == 5'(NUM_PE)) && (r_word == 4'd9);
    assign w_good_tail = w_fv && w_ftail && (r_pword == 2'd2) && !r_drop;
    assign w_capture   = w_good_tail && !r_found &&
                         ((r_state == S_SEND) || (r_state == S_COLLECT));

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A capture that lands during dispatch lets SEND finish, then skip COLLECT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)            w_next = S_SEND;
            S_SEND:         if (w_send && w_last) w_next = r_found ? S_DONE : S_COLLECT;
            S_COLLECT:      if (r_found)          w_next = S_DONE;
            default:                              w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_header      <= '0;
            r_pe_idx      <= '0;
            r_word        <= '0;
            r_credit_cnt  <= 4'(CREDIT_DEPTH);
            r_putFlit     <= '0;
            r_en_putFlit  <= 1'b0;
            r_send_credit <= 1'b0;
            r_credit_in   <= '0;
            r_pword       <= '0;
            r_drop        <= 1'b0;
            r_nonce       <= '0;
            r_found       <= 1'b0;
            r_found_pe    <= '0;
            r_found_nonce <= '0;
            r_found_clk   <= '0;
        end else begin
            // Simultaneous send and VC0 credit cancel out; count saturates at depth.
            if (w_send && !w_cr_in)
                r_credit_cnt <= r_credit_cnt - 4'd1;
            else if (!w_send && w_cr_in && (r_credit_cnt < 4'(CREDIT_DEPTH)))
                r_credit_cnt <= r_credit_cnt + 4'd1;

            r_en_putFlit <= 1'b0;
            if (w_start_ok) begin
                r_header <= header;
                r_pe_idx <= 5'd1;
                r_word   <= '0;
                r_found  <= 1'b0;
            end else if (w_send) begin
                r_putFlit    <= {1'b1, (r_word == 4'd9), r_pe_idx, 2'b00,
                                 r_header[64*r_word +: 64]};
                r_en_putFlit <= 1'b1;
                if (r_word == 4'd9) begin
                    r_word   <= '0;
                    r_pe_idx <= r_pe_idx + 5'd1;
                end else begin
                    r_word <= r_word + 4'd1;
                end
            end

            r_send_credit <= w_fv;
            r_credit_in   <= w_fv ? 3'b100 : 3'b000;

            if (w_fv) begin
                if (w_ftail) begin
                    r_pword <= '0;
                    r_drop  <= 1'b0;
                end else begin
                    if ((r_pword == 2'd0) && (w_fdata != 64'h1)) r_drop <= 1'b1;
                    if (r_pword == 2'd1) r_nonce <= w_fdata[31:0];
                    if (r_pword != 2'd3) r_pword <= r_pword + 2'd1;
                end
            end

            if (w_capture) begin
                r_found       <= 1'b1;
                r_found_nonce <= r_nonce;
                r_found_clk   <= w_fdata;
                r_found_pe    <= 5'((r_nonce % NUM_PE) + 32'd1);
            end
        end
    end

    assign noc.putFlit     = r_putFlit;
    assign noc.EN_putFlit  = r_en_putFlit;
    assign noc.send_credit = r_send_credit;
    assign noc.credit_in   = r_credit_in;
    assign busy            = (r_state == S_SEND) || (r_state == S_COLLECT);
    assign found           = r_found;
    assign found_pe        = r_found_pe;
    assign found_nonce     = r_found_nonce;
    assign found_clk       = r_found_clk;

endmodule

// File: tb/tb_header_dispatcher.sv
// Directed bench for header_dispatcher: flit scoreboard, per-cycle eject-credit check,
// credit stall/resume, result parsing and mid-dispatch reset.
module tb_header_dispatcher;
    localparam int unsigned NPE = 5;
    localparam int unsigned CD  = 4;

    logic         sys_clk = 1'b0;
    logic         reset   = 1'b0;
    logic         start   = 1'b0;
    logic [639:0] header  = '0;
    logic         busy;
    logic         found;
    logic [4:0]   found_pe;
    logic [31:0]  found_nonce;
    logic [63:0]  found_clk;

    header_dispatcher_if noc_if();

    header_dispatcher #(.NUM_PE(NPE), .CREDIT_DEPTH(CD)) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .start       (start),
        .header      (header),
        .noc         (noc_if),
        .busy        (busy),
        .found       (found),
        .found_pe    (found_pe),
        .found_nonce (found_nonce),
        .found_clk   (found_clk)
    );

    always #5 sys_clk = ~sys_clk;

    logic [72:0] sb[$];
    logic [72:0] inj[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_sent = 0;
    int cyc_n = 0;
    int first_t = -1;
    int last_t = -1;
    int cred_mode = 0;  // 0 none, 1 one per observed flit, 2 every cycle
    bit kick = 1'b0;
    bit exp_sc = 1'b0;
    logic [639:0] h;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [72:0] e;
        @(negedge sys_clk);
        cyc_n++;
        chk("eject_credit", 128'({noc_if.send_credit, noc_if.credit_in}),
            128'({exp_sc, (exp_sc ? 3'b100 : 3'b000)}));
        if (noc_if.EN_putFlit) begin
            n_sent++;
            if (first_t < 0) first_t = cyc_n;
            last_t = cyc_n;
            chk("flit_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("flit", 128'(noc_if.putFlit), 128'(e));
            end
        end
        noc_if.getCredit = (kick || cred_mode == 2 || (cred_mode == 1 && noc_if.EN_putFlit))
                           ? 3'b100 : 3'b000;
        kick = 1'b0;
        noc_if.flit = (inj.size() != 0) ? inj.pop_front() : '0;
        exp_sc = noc_if.flit[72];
    endtask

    task automatic push_hdr(input logic [639:0] hd);
        for (int unsigned p = 1; p <= NPE; p++)
            for (int unsigned w = 0; w < 10; w++)
                sb.push_back({1'b1, (w == 9), 5'(p), 2'b00, hd[64*w +: 64]});
    endtask

    task automatic inj_pkt(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
        inj.push_back({1'b1, 1'b0, 5'd0, 2'b00, w0});
        inj.push_back({1'b1, 1'b0, 5'd0, 2'b00, w1});
        inj.push_back({1'b1, 1'b1, 5'd0, 2'b00, w2});
    endtask

    task automatic do_start(input logic [639:0] hd);
        push_hdr(hd);
        n_sent = 0;
        first_t = -1;
        header = hd;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_until_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) cyc();
        chk("dispatch_complete", 128'(sb.size()), 128'(0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_flit"}, 128'({noc_if.EN_putFlit, noc_if.putFlit}), 128'(0));
        chk({tag, "_ecr"}, 128'({noc_if.send_credit, noc_if.credit_in}), 128'(0));
        chk({tag, "_busy_found"}, 128'({busy, found}), 128'(0));
        chk({tag, "_result"}, {found_pe, found_nonce, found_clk}, 128'(0));
    endtask

    initial begin
        noc_if.getCredit = '0;
        noc_if.flit = '0;
        repeat (3) @(negedge sys_clk);
        chk_zero_outputs("reset");
        reset = 1'b1;

        // Patterned header, credit returned one cycle after each flit.
        for (int unsigned w = 0; w < 10; w++) h[64*w +: 64] = {16{4'(w)}};
        cred_mode = 1;
        do_start(h);
        run_until_empty(200);
        chk("n_sent_full", 128'(n_sent), 128'(50));
        chk("back_to_back", 128'(last_t - first_t), 128'(49));
        chk("collect_busy", 128'(busy), 128'(1));
        cred_mode = 0;

        inj_pkt(64'h1, 64'h7, 64'd1234);
        repeat (3) cyc();
        chk("found_early", 128'(found), 128'(0));
        cyc();
        chk("found_a", 128'(found), 128'(1));
        chk("found_pe_a", 128'(found_pe), 128'(3));
        chk("found_nonce_a", 128'(found_nonce), 128'(7));
        chk("found_clk_a", 128'(found_clk), 128'(1234));
        chk("busy_before_done", 128'(busy), 128'(1));
        cyc();
        chk("done_a", 128'(busy), 128'(0));

        // No credit return: four flits, then a stall; a single credit releases one more.
        for (int unsigned w = 0; w < 20; w++) h[32*w +: 32] = $urandom;
        do_start(h);
        chk("found_cleared", 128'(found), 128'(0));
        repeat (20) cyc();
        chk("n_sent_stall", 128'(n_sent), 128'(4));
        kick = 1'b1;
        cyc();
        cyc();
        chk("no_early_send", 128'(noc_if.EN_putFlit), 128'(0));
        cyc();
        chk("credit_send", 128'(noc_if.EN_putFlit), 128'(1));
        repeat (10) cyc();
        chk("n_sent_one_more", 128'(n_sent), 128'(5));

        // Credit every cycle: count sits at 1 with send+return together, no bubbles.
        cred_mode = 2;
        first_t = -1;
        run_until_empty(200);
        chk("n_sent_total", 128'(n_sent), 128'(50));
        chk("same_cycle_no_stall", 128'(last_t - first_t), 128'(44));
        repeat (5) cyc();
        cred_mode = 0;

        // Bad packet dropped, good one captured, later one credited but ignored.
        inj_pkt(64'h2, 64'h5, 64'd99);
        inj_pkt(64'h1, 64'd10, 64'd555);
        repeat (6) cyc();
        chk("bad_dropped", 128'(found), 128'(0));
        cyc();
        chk("found_b", 128'(found), 128'(1));
        chk("found_pe_b", 128'(found_pe), 128'(1));
        chk("found_nonce_b", 128'(found_nonce), 128'(10));
        chk("found_clk_b", 128'(found_clk), 128'(555));
        cyc();
        chk("done_b", 128'(busy), 128'(0));
        inj_pkt(64'h1, 64'd11, 64'd777);
        repeat (5) cyc();
        chk("late_ignored", {found_pe, found_nonce, found_clk},
            128'({5'd1, 32'd10, 64'd555}));

        // Credits saturated at depth: exactly four flits before the stall.
        for (int unsigned w = 0; w < 20; w++) h[32*w +: 32] = $urandom;
        do_start(h);
        repeat (20) cyc();
        chk("n_sent_saturated", 128'(n_sent), 128'(4));
        cred_mode = 2;
        for (int i = 0; i < 100 && n_sent < 23; i++) cyc();
        chk("reached_flit_23", 128'(n_sent), 128'(23));

        #2 reset = 1'b0;
        #1 chk_zero_outputs("async_reset");
        cred_mode = 0;
        noc_if.getCredit = '0;
        noc_if.flit = '0;
        exp_sc = 1'b0;
        sb.delete();
        inj.delete();
        repeat (2) @(negedge sys_clk);
        reset = 1'b1;

        for (int unsigned w = 0; w < 20; w++) h[32*w +: 32] = $urandom;
        do_start(h);
        repeat (20) cyc();
        chk("n_sent_after_reset", 128'(n_sent), 128'(4));
        cred_mode = 2;
        run_until_empty(200);
        chk("n_sent_restart", 128'(n_sent), 128'(50));
        cred_mode = 0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/header_dispatcher.md
# header_dispatcher

Network controller at NoC node 0 that sequences the mining array. On `start` it sends one 640-bit block header as a 10-flit packet to each processing element (PE 1..NUM_PE), pacing sends with per-VC credit flow control. It then collects the 3-flit result packets that PEs return to node 0 and reports the first winning nonce, its PE and its cycle count to the host logic.

## Interface
- NUM_PE, 5: number of PEs, ids 1..NUM_PE; also the nonce stride used by the PEs (1..31).
- CREDIT_DEPTH, 4: initial send credits for VC0 (router input buffer depth, 1..15).
- sys_clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted in IDLE or DONE only.
- header  in  640  block header; latched on accepted `start`.
- putFlit  out  73  {valid, tail, dest[4:0], vc[1:0], data[63:0]}.
- EN_putFlit  out  1  putFlit is valid this cycle.
- getCredit  in  3  {valid, vc[1:0]}; credit returned by router for our send port.
- flit  in  73  ejected flit, same format as putFlit; valid = bit 72.
- send_credit  out  1  credit return strobe for the eject port.
- credit_in  out  3  {valid, vc}; 3'b100 when returning a VC0 credit.
- busy  out  1  high in SEND and COLLECT.
- found  out  1  result registers valid; held until next accepted `start`.
- found_pe  out  5  PE that found the nonce.
- found_nonce  out  32  winning nonce.
- found_clk  out  64  PE cycle count reported with the nonce.

## Operation
- States: IDLE, SEND, COLLECT, DONE.
- IDLE/DONE --start--> SEND: latch header, clear found, pe_idx←1, word←0, credit_cnt unchanged.
- SEND: emit a flit when credit_cnt != 0: data = header[64*word +: 64], dest = pe_idx, vc = 0, tail = (word == 9), valid = 1. Advance word 0..9; after word 9 advance pe_idx; after (NUM_PE, 9) go to COLLECT. When credit_cnt == 0, stall with EN_putFlit = 0; position held.
- credit_cnt (4 bits): reset to CREDIT_DEPTH; −1 per send; +1 on getCredit == 3'b100; both in the same cycle leaves it unchanged; credits on VC ≠ 0 ignored. Never exceeds CREDIT_DEPTH.
- Eject side, every state, reset excepted: each cycle with flit[72] = 1 produces send_credit = 1, credit_in = 3'b100 on the next cycle; otherwise both 0. Flits are never back-pressured.
- Result parser (3-word counter, reset on tail): word0 must be data == 64'h1, else the packet is discarded up to and including its tail. word1: nonce = data[31:0]. word2 (tail): cycle count = data.
- Capture: on a well-formed tail while in SEND or COLLECT and found == 0, load found_nonce, found_clk, found_pe = (nonce mod NUM_PE) + 1; set found. From COLLECT go to DONE on the following cycle. A capture during SEND does not interrupt dispatch; SEND then goes straight to DONE.
- Later results and flits in IDLE/DONE are credited and discarded; found registers unchanged.
- start during SEND or COLLECT ignored.

## Timing
- Reset (async, low): state IDLE, putFlit 0, EN_putFlit 0, send_credit 0, credit_in 0, busy 0, found 0, found_pe 0, found_nonce 0, found_clk 0, credit_cnt CREDIT_DEPTH, parser cleared. Reset mid-packet truncates it; no recovery flits are sent.
- putFlit/EN_putFlit registered: first flit is visible the cycle after the start edge; EN_putFlit high exactly one cycle per flit.
- A credit returned in cycle t is usable for a send decision in cycle t+1.
- Dispatch with no stall: 10·NUM_PE consecutive flits (50 for default).
- Credit return latency: exactly 1 cycle after the flit is sampled.
- found rises 1 cycle after the tail flit is sampled; DONE is entered 1 cycle later.
- putFlit holds its last value when EN_putFlit = 0; the bench checks it only when EN_putFlit = 1.

## Test plan
- Reset then start with header = word w filled with 64'h(w)… (w = 0..9), CREDIT_DEPTH credits returned 1 cycle after each send -> 50 back-to-back flits; flit for PE 3, word 9 has dest 3, tail 1, data = header[639:576].
- No credits returned -> exactly 4 flits sent, then EN_putFlit stays 0; return one credit -> exactly one more flit, sent the next cycle.
- Same-cycle send and credit return with credit_cnt = 1 -> count stays 1 and no stall occurs.
- During COLLECT inject {64'h1, 64'h0000_0000_0000_0007, 64'd1234} -> found = 1, found_pe = 3, found_nonce = 7, found_clk = 1234, DONE; 3 credits of 3'b100, each 1 cycle after its flit.
- Inject a bad packet (word0 = 64'h2), then a good packet with nonce 10 -> bad packet dropped, found_pe = 1; a second good packet with nonce 11 -> ignored but credited.
- Assert reset mid-SEND at flit 23 -> all outputs 0 asynchronously, credit_cnt = 4; a new start restarts from PE 1, word 0.
